// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stall, branch redirect flush, and multi-cycle mul/div hold.
// Stall/flush outputs are combinational, same cycle. The mul/div sequencer holds the pipeline for exactly LAT cycles.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] D_Rs1,
  input  logic [4:0] D_Rs2,
  input  logic [4:0] E_Rd,
  input  logic       E_RegWrite,
  input  logic [1:0] E_ResultSrc,
  input  logic       E_PCSrc,
  input  logic       E_MdValid,
  input  logic       E_MdIsDiv,
  output logic       F_Stall,
  output logic       D_Stall,
  output logic       E_Stall,
  output logic       D_Flush,
  output logic       E_Flush,
  output logic       M_Bubble,
  output logic       md_start,
  output logic       md_busy,
  output logic [5:0] md_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [5:0] cnt_nxt;
  logic [5:0] lat_cnt;
  logic       start_raw;
  logic       lw_stall;

  assign lat_cnt = E_MdIsDiv ? DIV_CNT : MUL_CNT;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = md_cnt;
    start_raw = 1'b0;
    case (state)
      S_IDLE: begin
        if (E_MdValid) begin
          start_raw = 1'b1;
          cnt_nxt   = lat_cnt;
          state_nxt = (lat_cnt == 6'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // <=1 rather than ==1 so a corrupted zero count cannot wrap into a 63-cycle hang
        if (md_cnt <= 6'd1) begin
          cnt_nxt   = 6'd0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = md_cnt - 6'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      md_cnt <= 6'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= cnt_nxt;
    end
  end

  // Reset forces IDLE asynchronously, but E_MdValid may still be high, so gate the start explicitly
  assign md_start = start_raw & ~rst;
  assign md_busy  = md_start | (state == S_RUN);

  assign lw_stall = (E_ResultSrc == 2'b01) && E_RegWrite && (E_Rd != 5'd0) &&
                    ((D_Rs1 == E_Rd) || (D_Rs2 == E_Rd));

  always_comb begin
    F_Stall  = 1'b0;
    D_Stall  = 1'b0;
    E_Stall  = 1'b0;
    D_Flush  = 1'b0;
    E_Flush  = 1'b0;
    M_Bubble = 1'b0;
    if (md_busy) begin
      F_Stall  = 1'b1;
      D_Stall  = 1'b1;
      E_Stall  = 1'b1;
      M_Bubble = 1'b1;
    end else if (E_PCSrc) begin
      D_Flush = 1'b1;
      E_Flush = 1'b1;
    end else if (lw_stall) begin
      F_Stall = 1'b1;
      D_Stall = 1'b1;
      E_Flush = 1'b1;
    end
  end

endmodule
